// File: rtl/nand_cpu_pkg.sv
// Shared types and widths for the nand_cpu pipeline control slice.
package nand_cpu_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int INT_CODE_W = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a decode source matches the destination of a load sitting in act.
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  d_valid,
  input  logic                  d_use_rs0,
  input  logic                  d_use_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs0_addr,
  input  logic [REG_ADDR_W-1:0] d_rs1_addr,
  input  logic                  a_valid,
  input  logic                  a_mem_read,
  input  logic                  a_reg_write,
  input  logic [REG_ADDR_W-1:0] a_reg_addr,
  output logic                  load_use
);
  logic rs0_hit;
  logic rs1_hit;

  assign rs0_hit  = d_use_rs0 && (d_rs0_addr == a_reg_addr);
  assign rs1_hit  = d_use_rs1 && (d_rs1_addr == a_reg_addr);
  assign load_use = d_valid && a_valid && a_mem_read && a_reg_write && (rs0_hit || rs1_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: priority mux of retain/clear controls, run/halt state and stall counter.
module pipeline_hazard_ctrl
  import nand_cpu_pkg::*;
#(
  parameter int REG_ADDR_W = nand_cpu_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  d_valid,
  input  logic                  d_use_rs0,
  input  logic                  d_use_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs0_addr,
  input  logic [REG_ADDR_W-1:0] d_rs1_addr,
  input  logic                  a_valid,
  input  logic                  a_mem_read,
  input  logic                  a_reg_write,
  input  logic [REG_ADDR_W-1:0] a_reg_addr,
  input  logic                  a_mispredict,
  input  logic                  dc_busy,
  input  logic                  w_valid,
  input  logic                  w_halt,
  input  logic                  w_interrupt,
  input  logic [INT_CODE_W-1:0] w_int_code,
  output logic                  i2d_retain,
  output logic                  i2d_clear,
  output logic                  d2a_retain,
  output logic                  d2a_clear,
  output logic                  a2w_retain,
  output logic                  a2w_clear,
  output logic                  fetch_stall,
  output logic                  redirect,
  output logic                  int_taken,
  output logic [INT_CODE_W-1:0] int_code,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output ctrl_state_t           dbg_state
);
  ctrl_state_t           state_q;
  logic [INT_CODE_W-1:0] int_code_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic                  load_use;
  logic                  retire;
  logic                  count_en;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .d_valid     (d_valid),
    .d_use_rs0   (d_use_rs0),
    .d_use_rs1   (d_use_rs1),
    .d_rs0_addr  (d_rs0_addr),
    .d_rs1_addr  (d_rs1_addr),
    .a_valid     (a_valid),
    .a_mem_read  (a_mem_read),
    .a_reg_write (a_reg_write),
    .a_reg_addr  (a_reg_addr),
    .load_use    (load_use)
  );

  assign retire = w_valid && (w_halt || w_interrupt);

  // Priority: retire > d-cache busy > mispredict > load-use; a mispredict waits out dc_busy.
  always_comb begin
    i2d_retain  = 1'b0;
    i2d_clear   = 1'b0;
    d2a_retain  = 1'b0;
    d2a_clear   = 1'b0;
    a2w_retain  = 1'b0;
    a2w_clear   = 1'b0;
    fetch_stall = 1'b0;
    redirect    = 1'b0;
    int_taken   = 1'b0;
    if (!n_rst) begin
      fetch_stall = 1'b0;
    end else if (state_q == HALTED) begin
      i2d_clear   = 1'b1;
      d2a_clear   = 1'b1;
      a2w_clear   = 1'b1;
      fetch_stall = 1'b1;
    end else if (retire) begin
      i2d_clear   = 1'b1;
      d2a_clear   = 1'b1;
      a2w_clear   = 1'b1;
      fetch_stall = w_halt;
      int_taken   = !w_halt;
    end else if (dc_busy && a_valid) begin
      i2d_retain  = 1'b1;
      d2a_retain  = 1'b1;
      a2w_clear   = 1'b1;
      fetch_stall = 1'b1;
    end else if (a_valid && a_mispredict) begin
      i2d_clear   = 1'b1;
      d2a_clear   = 1'b1;
      redirect    = 1'b1;
    end else if (load_use) begin
      fetch_stall = 1'b1;
      i2d_retain  = 1'b1;
      d2a_clear   = 1'b1;
    end
  end

  assign count_en = (state_q == RUN) &&
                    (fetch_stall || i2d_clear || d2a_clear || a2w_clear);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= RUN;
      int_code_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_valid && w_halt) begin
            state_q <= HALTED;
          end else if (w_valid && w_interrupt) begin
            int_code_q <= w_int_code;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= RUN;
      endcase
      if (count_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign int_code  = int_code_q;
  assign stall_cnt = stall_cnt_q;
  assign halted    = (state_q == HALTED);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;
  import nand_cpu_pkg::*;

  localparam int CNT_W = 4;
  localparam int EXP_W = 10 + 4 + CNT_W;

  // Control bit positions: {i2d_r,i2d_c,d2a_r,d2a_c,a2w_r,a2w_c,fs,redirect,int_taken,halted}
  localparam logic [9:0] I2R = 10'b10_0000_0000;
  localparam logic [9:0] I2C = 10'b01_0000_0000;
  localparam logic [9:0] D2R = 10'b00_1000_0000;
  localparam logic [9:0] D2C = 10'b00_0100_0000;
  localparam logic [9:0] A2C = 10'b00_0001_0000;
  localparam logic [9:0] FS  = 10'b00_0000_1000;
  localparam logic [9:0] RD  = 10'b00_0000_0100;
  localparam logic [9:0] IT  = 10'b00_0000_0010;
  localparam logic [9:0] HLT = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;

  logic clk = 1'b0;
  logic n_rst;
  logic d_valid, d_use_rs0, d_use_rs1;
  logic [3:0] d_rs0_addr, d_rs1_addr;
  logic a_valid, a_mem_read, a_reg_write, a_mispredict, dc_busy;
  logic [3:0] a_reg_addr;
  logic w_valid, w_halt, w_interrupt;
  logic [3:0] w_int_code;
  logic i2d_retain, i2d_clear, d2a_retain, d2a_clear, a2w_retain, a2w_clear;
  logic fetch_stall, redirect, int_taken, halted;
  logic [3:0] int_code;
  logic [CNT_W-1:0] stall_cnt;
  ctrl_state_t dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .d_valid(d_valid), .d_use_rs0(d_use_rs0), .d_use_rs1(d_use_rs1),
    .d_rs0_addr(d_rs0_addr), .d_rs1_addr(d_rs1_addr),
    .a_valid(a_valid), .a_mem_read(a_mem_read), .a_reg_write(a_reg_write),
    .a_reg_addr(a_reg_addr), .a_mispredict(a_mispredict), .dc_busy(dc_busy),
    .w_valid(w_valid), .w_halt(w_halt), .w_interrupt(w_interrupt), .w_int_code(w_int_code),
    .i2d_retain(i2d_retain), .i2d_clear(i2d_clear),
    .d2a_retain(d2a_retain), .d2a_clear(d2a_clear),
    .a2w_retain(a2w_retain), .a2w_clear(a2w_clear),
    .fetch_stall(fetch_stall), .redirect(redirect), .int_taken(int_taken),
    .int_code(int_code), .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    d_valid = 0; d_use_rs0 = 0; d_use_rs1 = 0; d_rs0_addr = 0; d_rs1_addr = 0;
    a_valid = 0; a_mem_read = 0; a_reg_write = 0; a_reg_addr = 0;
    a_mispredict = 0; dc_busy = 0;
    w_valid = 0; w_halt = 0; w_interrupt = 0; w_int_code = 0;
  endtask

  task automatic set_load(input logic [3:0] rd);
    a_valid = 1; a_mem_read = 1; a_reg_write = 1; a_reg_addr = rd;
  endtask

  // Inputs already driven; record what this cycle must show, then advance one clock.
  task automatic issue(input logic [9:0] e_ctl, input logic [3:0] e_code,
                       input logic [CNT_W-1:0] e_cnt);
    exp_q.push_back({e_ctl, e_code, e_cnt});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [9:0] act_ctl;
      logic [4+CNT_W-1:0] act_reg;
      e = exp_q.pop_front();
      act_ctl = {i2d_retain, i2d_clear, d2a_retain, d2a_clear, a2w_retain, a2w_clear,
                 fetch_stall, redirect, int_taken, halted};
      act_reg = {int_code, stall_cnt};
      n_checks++;
      if (act_ctl !== e[EXP_W-1 -: 10]) begin
        n_errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, act_ctl, e[EXP_W-1 -: 10]);
      end
      n_checks++;
      if (act_reg !== e[4+CNT_W-1:0]) begin
        n_errors++;
        $display("FAIL code_cnt @%0t: got code=%h cnt=%0d expected code=%h cnt=%0d",
                 $time, act_reg[4+CNT_W-1 -: 4], act_reg[CNT_W-1:0],
                 e[4+CNT_W-1 -: 4], e[CNT_W-1:0]);
      end
      n_checks++;
      if ((i2d_retain && i2d_clear) || (d2a_retain && d2a_clear) || (a2w_retain && a2w_clear)) begin
        n_errors++;
        $display("FAIL retain_clear_overlap @%0t: got %b expected no overlap", $time, act_ctl);
      end
    end
  end

  initial begin
    idle_inputs();
    n_rst = 0;
    @(posedge clk); #1;
    issue(NONE, 4'h0, 0);                        // held in reset
    n_rst = 1;
    issue(NONE, 4'h0, 0);                        // idle after reset

    set_load(4'd3); d_valid = 1; d_use_rs1 = 1; d_rs1_addr = 4'd3;
    issue(I2R | D2C | FS, 4'h0, 0);              // load-use on rs1
    idle_inputs();
    issue(NONE, 4'h0, 1);

    set_load(4'd3); d_valid = 1; d_rs0_addr = 4'd3; d_use_rs1 = 1; d_rs1_addr = 4'd5;
    issue(NONE, 4'h0, 1);                        // rs0 matches but unused
    idle_inputs();
    a_valid = 1; a_reg_write = 1; a_reg_addr = 4'd3; d_valid = 1; d_use_rs1 = 1; d_rs1_addr = 4'd3;
    issue(NONE, 4'h0, 1);                        // not a load: no hazard

    idle_inputs();
    a_valid = 1; a_mispredict = 1; dc_busy = 1;
    issue(I2R | D2R | A2C | FS, 4'h0, 1);
    issue(I2R | D2R | A2C | FS, 4'h0, 2);
    issue(I2R | D2R | A2C | FS, 4'h0, 3);
    dc_busy = 0;
    issue(I2C | D2C | RD, 4'h0, 4);              // deferred mispredict
    idle_inputs();
    issue(NONE, 4'h0, 5);

    set_load(4'd7); a_mispredict = 1; d_valid = 1; d_use_rs0 = 1; d_rs0_addr = 4'd7;
    issue(I2C | D2C | RD, 4'h0, 5);              // mispredict beats load-use
    idle_inputs();
    dc_busy = 1;
    issue(NONE, 4'h0, 6);                        // dc_busy without act valid

    idle_inputs();
    w_valid = 1; w_interrupt = 1; w_int_code = 4'hA;
    issue(I2C | D2C | A2C | IT, 4'h0, 6);
    idle_inputs();
    issue(NONE, 4'hA, 7);
    w_interrupt = 1; w_int_code = 4'h3;
    issue(NONE, 4'hA, 7);                        // interrupt without w_valid

    idle_inputs();
    w_valid = 1; w_halt = 1; w_interrupt = 1; w_int_code = 4'h5;
    issue(I2C | D2C | A2C | FS, 4'hA, 7);        // halt wins over interrupt
    idle_inputs();
    a_valid = 1; dc_busy = 1; a_mispredict = 1;
    issue(I2C | D2C | A2C | FS | HLT, 4'hA, 8);
    idle_inputs();
    w_valid = 1; w_interrupt = 1; w_int_code = 4'h3;
    issue(I2C | D2C | A2C | FS | HLT, 4'hA, 8);  // ignored while halted
    idle_inputs();
    n_rst = 0;
    issue(HLT, 4'hA, 8);                         // outputs gated, state still halted
    n_rst = 1;
    issue(NONE, 4'h0, 0);

    a_valid = 1; dc_busy = 1;
    for (int i = 0; i < 18; i++) begin
      issue(I2R | D2R | A2C | FS, 4'h0, (i > 15) ? 4'd15 : 4'(i));
    end
    idle_inputs();
    issue(NONE, 4'h0, 15);                       // saturated

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the three pipeline registers (i2d, d2a, a2w) and the fetch PC.
- Generates per-stage retain and clear from four sources: load-use hazards, d-cache busy, branch mispredicts in the act stage, and halt/interrupt retirement at writeback.
- Tracks a run/halted state and counts stall cycles for performance visibility.

Parameters:
- REG_ADDR_W, 4, register-file address width.
- CNT_W, 16, width of the stall-cycle counter; the counter saturates at its maximum.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- d_valid  in  1  decode-stage instruction valid
- d_use_rs0  in  1  decode instruction reads rs0
- d_use_rs1  in  1  decode instruction reads rs1
- d_rs0_addr  in  REG_ADDR_W  decode source 0
- d_rs1_addr  in  REG_ADDR_W  decode source 1
- a_valid  in  1  act-stage instruction valid
- a_mem_read  in  1  act instruction is a load
- a_reg_write  in  1  act instruction writes a register
- a_reg_addr  in  REG_ADDR_W  act destination register
- a_mispredict  in  1  act-stage branch feedback: predicted taken/target differs from actual
- dc_busy  in  1  d-cache cannot complete the act-stage access this cycle
- w_valid  in  1  writeback instruction valid
- w_halt  in  1  writeback instruction is a halt
- w_interrupt  in  1  writeback instruction raises an interrupt
- w_int_code  in  4  interrupt code
- i2d_retain, i2d_clear  out  1 each  i2d pipeline-register control
- d2a_retain, d2a_clear  out  1 each  d2a pipeline-register control
- a2w_retain, a2w_clear  out  1 each  a2w pipeline-register control
- fetch_stall  out  1  hold the PC
- redirect  out  1  fetch takes the corrected target from branch feedback
- int_taken  out  1  pulse: fetch takes the interrupt vector
- int_code  out  4  code of the last taken interrupt (registered)
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  total stall and bubble cycles

Behaviour:
- Timing: all retain/clear/stall/redirect/int_taken outputs are combinational from the current inputs and state, and act at the next clk edge. State, int_code and stall_cnt are registered.
- Reset values: state=RUN, int_code=0, stall_cnt=0, halted=0. Combinational outputs are 0 while n_rst is low. Reset mid-stall or while HALTED returns to RUN on the next edge.
- States: RUN and HALTED.
  - RUN -> HALTED on w_valid & w_halt.
  - HALTED exits only via reset.
- HALTED: all clears=1, fetch_stall=1, halted=1, retains=0. All other inputs are ignored.
- RUN: the first matching case below wins; everything not listed is 0.
  1. Retire event, w_valid & (w_halt | w_interrupt):
     - i2d_clear, d2a_clear and a2w_clear = 1.
     - Halt: fetch_stall=1 and transition to HALTED.
     - Interrupt only: int_taken=1 and int_code <= w_int_code.
     - If both are set, halt wins and int_taken=0.
  2. dc_busy & a_valid:
     - i2d_retain=1, d2a_retain=1, fetch_stall=1.
     - a2w_clear=1 (bubble into writeback). a2w_retain=0.
     - An a_mispredict is deferred until dc_busy drops.
  3. a_valid & a_mispredict:
     - i2d_clear=1, d2a_clear=1, redirect=1. a2w loads normally.
     - A simultaneous load-use hazard is ignored, since the decode instruction is squashed.
  4. Load-use hazard:
     - Condition: d_valid & a_valid & a_mem_read & a_reg_write & ((d_use_rs0 & d_rs0_addr==a_reg_addr) | (d_use_rs1 & d_rs1_addr==a_reg_addr)).
     - Response: fetch_stall=1, i2d_retain=1, d2a_clear=1. a2w loads normally.
     - Lasts exactly one cycle, because the load moves to writeback and is forwarded.
  5. Otherwise: all zero, normal advance.
- Invariant: retain and clear are never both 1 for the same register.
- stall_cnt: increments by 1 in any RUN cycle where fetch_stall=1 or any clear=1. Saturates at 2^CNT_W-1. Holds while HALTED.

Decomposition:
- Shared package nand_cpu_pkg:
  - typedef ctrl_state_t {RUN, HALTED}
  - REG_ADDR_W
  - int-code width constant (4)
- Sub-module hazard_detect: purely combinational load-use comparator returning one bit.
- Sequencer, counter and priority mux stay in the top module.

Test Plan:
- Load r3 in act, decode reads rs1=r3 with d_use_rs1=1 -> one cycle of fetch_stall=1, i2d_retain=1, d2a_clear=1; next cycle all 0; stall_cnt=1.
- Same load with decode reading rs0=r3 but d_use_rs0=0 -> no stall, all outputs 0.
- dc_busy=1 for 3 cycles with a_mispredict=1 -> 3 cycles of i2d/d2a retain=1, a2w_clear=1, redirect=0; the cycle after dc_busy drops gives redirect=1, i2d_clear=d2a_clear=1; stall_cnt=4.
- Mispredict plus load-use in the same cycle -> redirect=1, i2d_clear=d2a_clear=1, i2d_retain=0, fetch_stall=0.
- w_valid=1, w_interrupt=1, w_int_code=4'hA -> int_taken=1 for one cycle, all clears=1; int_code=4'hA the following cycle; state stays RUN.
- w_valid=1 with w_halt=1 and w_interrupt=1 -> int_taken=0 and halted=1 from the next cycle; dc_busy/mispredict toggled while halted have no effect; n_rst low for one edge -> RUN, halted=0, stall_cnt=0, int_code=0.
